// File: rtl/ltc_spi_master_if.sv
// Command/response bus between the temperature-monitor control FSM and the LTC2986 SPI master.
interface ltc_spi_master_if;
  logic [6:0][7:0] tx;
  logic [2:0]      spi_n;
  logic            spi_go;
  logic [6:0][7:0] rx;
  logic            spi_ok;
  logic [3:0]      ss_state;

  modport master (output tx, spi_n, spi_go, input rx, spi_ok, ss_state);
  modport slave  (input tx, spi_n, spi_go, output rx, spi_ok, ss_state);
endinterface

// File: rtl/ltc_spi_master.sv
// Mode-0 SPI master: up to 7 bytes MSB-first per chip-select frame, MISO captured into rx bytes.
// States: IDLE=0 wait go | SETUP=1 cs_n low | LOW=2 sck low | HIGH=3 sck high | HOLD=4 cs hold | GAP=5 cs_n high
module ltc_spi_master #(
  parameter int CLK_DIV  = 6,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ltc_spi_master_if.slave bus,
  output logic            sck_o,
  output logic            mosi_o,
  input  logic            miso_i,
  output logic            cs_n_o
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SETUP = 4'd1,
    LOW   = 4'd2,
    HIGH  = 4'd3,
    HOLD  = 4'd4,
    GAP   = 4'd5
  } state_t;

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [5:0]      bit_q;
  logic [2:0]      n_q;
  logic [54:0]     tx_sh_q;
  logic [6:0]      rx_sh_q;
  logic [6:0][7:0] rx_q;
  logic            sck_q;
  logic            mosi_q;
  logic            cs_n_q;
  logic            ok_q;

  logic       last_bit;
  logic [7:0] rx_byte_d;

  assign last_bit  = (bit_q == {n_q - 3'd1, 3'b111});
  assign rx_byte_d = {rx_sh_q, miso_i};

  assign sck_o        = sck_q;
  assign mosi_o       = mosi_q;
  assign cs_n_o       = cs_n_q;
  assign bus.rx       = rx_q;
  assign bus.spi_ok   = ok_q;
  assign bus.ss_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 6'd0;
      n_q     <= 3'd0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ok_q    <= 1'b0;
    end else begin
      ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.spi_go && bus.spi_n != 3'd0) begin
            state_q <= SETUP;
            n_q     <= bus.spi_n;
            // MSB of tx0 goes straight to mosi; the rest waits in the shifter
            tx_sh_q <= {bus.tx[0][6:0], bus.tx[1], bus.tx[2], bus.tx[3],
                        bus.tx[4], bus.tx[5], bus.tx[6]};
            mosi_q  <= bus.tx[0][7];
            bit_q   <= 6'd0;
            cnt_q   <= 8'(CS_SETUP - 1);
            cs_n_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_q == 8'd0) begin
            state_q <= LOW;
            cnt_q   <= 8'(CLK_DIV - 1);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        LOW: begin
          if (cnt_q == 8'd0) begin
            state_q <= HIGH;
            cnt_q   <= 8'(CLK_DIV - 1);
            sck_q   <= 1'b1;
            rx_sh_q <= rx_byte_d[6:0];
            for (int k = 0; k < 7; k++) begin
              if (bit_q[2:0] == 3'd7 && bit_q[5:3] == 3'(k)) rx_q[k] <= rx_byte_d;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        HIGH: begin
          if (cnt_q == 8'd0) begin
            sck_q <= 1'b0;
            if (last_bit) begin
              state_q <= HOLD;
              cnt_q   <= 8'(CS_HOLD - 1);
            end else begin
              state_q <= LOW;
              cnt_q   <= 8'(CLK_DIV - 1);
              bit_q   <= bit_q + 6'd1;
              mosi_q  <= tx_sh_q[54];
              tx_sh_q <= {tx_sh_q[53:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 8'd0) begin
            state_q <= GAP;
            cnt_q   <= 8'(CS_IDLE - 1);
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        GAP: begin
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
            ok_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ltc_spi_master.sv
// Scoreboard bench for ltc_spi_master: stimulus pushes expected frames, a monitor checks each spi_ok.
module tb_ltc_spi_master;
  logic clk = 1'b0;
  logic rst_n;
  logic sck_o, mosi_o, miso_i, cs_n_o;

  ltc_spi_master_if bus();

  ltc_spi_master dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sck_o  (sck_o),
    .mosi_o (mosi_o),
    .miso_i (miso_i),
    .cs_n_o (cs_n_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0][7:0] rx;
    logic [55:0]     mosi;
    int              n;
    int              go_cyc;
  } exp_t;

  exp_t            sb[$];
  int              comp_cnt = 0;
  int              fail_cnt = 0;
  int              cyc = 0;
  logic [6:0][7:0] rx_model = '0;

  always @(posedge clk) cyc++;

  // Mode-0 slave: bit 55 of slave_data is presented while cs_n is high, next bit after each sck fall
  logic [55:0] slave_data = '0;
  bit          loopback = 1'b0;
  int          slv_idx = 0;
  logic        slv_sck_prev = 1'b0;
  always @(negedge clk) begin
    if (cs_n_o) slv_idx = 0;
    else if (slv_sck_prev && !sck_o) slv_idx++;
    slv_sck_prev = sck_o;
  end
  assign miso_i = loopback ? mosi_o : ((slv_idx < 56) ? slave_data[55 - slv_idx] : 1'b0);

  // monitor state
  int          n_ok = 0, n_fall = 0, rises = 0, cs_low = 0, last_cs_low = 0, gap = 0;
  logic [55:0] cap = '0;
  logic        sck_prev = 1'b0, cs_prev = 1'b1;
  bit          ok_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    comp_cnt++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [6:0][7:0] mk(input logic [55:0] s);
    logic [6:0][7:0] r;
    for (int k = 0; k < 7; k++) r[k] = s[55 - 8*k -: 8];
    return r;
  endfunction

  task automatic issue(input logic [6:0][7:0] tx, input int n, input logic [55:0] slv, input bit lb);
    exp_t e;
    bus.tx     = tx;
    bus.spi_n  = 3'(n);
    slave_data = slv;
    loopback   = lb;
    for (int k = 0; k < n; k++) rx_model[k] = lb ? tx[k] : slv[55 - 8*k -: 8];
    e.rx     = rx_model;
    e.n      = n;
    e.go_cyc = cyc;
    e.mosi   = {tx[0], tx[1], tx[2], tx[3], tx[4], tx[5], tx[6]} >> (8 * (7 - n));
    sb.push_back(e);
    bus.spi_go = 1'b1;
  endtask

  task automatic go_frame(input logic [55:0] txs, input int n, input logic [55:0] slv, input bit lb);
    @(negedge clk);
    issue(mk(txs), n, slv, lb);
    @(negedge clk);
    bus.spi_go = 1'b0;
  endtask

  task automatic wait_ok(input int target);
    int t = 0;
    while (n_ok < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("done_%0d", target), 64'(n_ok >= target), 64'd1);
  endtask

  task automatic wait_rises(input int r, input string name);
    int t = 0;
    while (!(rises >= r && sck_o) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(t < 3000), 64'd1);
  endtask

  initial begin
    int t;
    rst_n      = 1'b0;
    bus.tx     = '0;
    bus.spi_n  = 3'd0;
    bus.spi_go = 1'b0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (ok_chk) begin
            chk("ok_width", 64'(bus.spi_ok), 64'd0);
            ok_chk = 1'b0;
          end
          if (!cs_n_o && cs_prev) begin
            n_fall++;
            chk("cs_gap_ge4", 64'(gap >= 4), 64'd1);
            gap = 0; cap = '0; rises = 0; cs_low = 0;
          end
          if (cs_n_o && !cs_prev) last_cs_low = cs_low;
          if (cs_n_o) gap++; else cs_low++;
          if (sck_o && !sck_prev) begin
            cap = {cap[54:0], mosi_o};
            rises++;
          end
          sck_prev = sck_o;
          cs_prev  = cs_n_o;
          if (bus.spi_ok) begin
            n_ok++;
            ok_chk = 1'b1;
            if (sb.size() == 0) begin
              chk("unexpected_ok", 64'd1, 64'd0);
            end else begin
              e = sb.pop_front();
              chk("rx", 64'(e.rx), 64'(bus.rx));
              chk("rx_vs_model", 64'(bus.rx), 64'(e.rx));
              chk("state_at_ok", 64'(bus.ss_state), 64'd0);
              chk("latency", 64'(cyc - e.go_cyc), 64'(96 * e.n + 9));
              chk("mosi_stream", 64'(cap), 64'(e.mosi));
              chk("sck_rises", 64'(rises), 64'(8 * e.n));
              chk("cs_low_len", 64'(last_cs_low), 64'(96 * e.n + 4));
              chk("idle_pins", 64'({cs_n_o, sck_o, mosi_o}), 64'(3'b100));
            end
          end
        end
      end
    join_none

    @(posedge clk); #1;
    chk("rst_pins", 64'({cs_n_o, sck_o, mosi_o}), 64'(3'b100));
    chk("rst_state", 64'(bus.ss_state), 64'd0);
    chk("rst_ok", 64'(bus.spi_ok), 64'd0);
    chk("rst_rx", 64'(bus.rx), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // default write frame, slave preloads rx with AA
    go_frame(56'h0202_18E8_1770_00, 7, {7{8'hAA}}, 1'b0);
    wait_ok(1);
    // 4-byte status read; rx4..rx6 keep AA
    go_frame(56'h0300_0000_5566_77, 4, 56'h0000_0040_0000_00, 1'b0);
    wait_ok(2);
    // 7-byte read
    go_frame(56'h0300_0200_0000_00, 7, 56'h0000_0001_1900_00, 1'b0);
    wait_ok(3);
    // loopback frame, then a back-to-back frame issued in its spi_ok cycle
    go_frame(56'hA53C_0FF0_817E_C3, 7, 56'h0, 1'b1);
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!bus.spi_ok && t < 3000);
    chk("b2b_ok_seen", 64'(bus.spi_ok), 64'd1);
    issue(mk(56'h5AC3_0000_0000_00), 2, 56'h0, 1'b1);
    @(posedge clk); #1;
    bus.spi_go = 1'b0;
    chk("b2b_setup", 64'(bus.ss_state), 64'd1);
    wait_ok(5);

    // spi_go during HIGH of byte 2 must be ignored
    go_frame(56'h0102_0304_0506_0A, 7, 56'h1122_3344_5566_77, 1'b0);
    wait_rises(17, "reach_byte2_high");
    @(negedge clk);
    bus.tx     = mk(56'hFFFF_FFFF_FFFF_FF);
    bus.spi_n  = 3'd3;
    bus.spi_go = 1'b1;
    @(negedge clk);
    bus.spi_go = 1'b0;
    wait_ok(6);
    // spi_n = 0 while idle: no frame
    @(negedge clk);
    bus.spi_n  = 3'd0;
    bus.spi_go = 1'b1;
    @(negedge clk);
    bus.spi_go = 1'b0;
    repeat (30) @(negedge clk);
    chk("n0_state", 64'(bus.ss_state), 64'd0);
    chk("n0_cs", 64'(cs_n_o), 64'd1);

    // async reset in the middle of byte 3
    go_frame(56'h1234_5678_9ABC_DE, 7, 56'hFEDC_BA98_7654_32, 1'b0);
    wait_rises(28, "reach_byte3");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_pins", 64'({cs_n_o, sck_o, mosi_o}), 64'(3'b100));
    chk("abort_state", 64'(bus.ss_state), 64'd0);
    chk("abort_rx", 64'(bus.rx), 64'd0);
    void'(sb.pop_back());
    rx_model = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    chk("abort_no_ok", 64'(n_ok), 64'd6);

    go_frame(56'hC0FF_EE00_0000_00, 3, 56'h9ABC_DE00_0000_00, 1'b0);
    wait_ok(7);

    repeat (5) @(negedge clk);
    chk("cs_falls", 64'(n_fall), 64'd8);
    chk("ok_count", 64'(n_ok), 64'd7);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ltc_spi_master.md
Name: ltc_spi_master

Overview:
- SPI master, mode 0 (CPOL=0, CPHA=0), that serves the temperature-monitor control FSM and drives the LTC2986 pins.
- Upstream, the FSM loads up to 7 bytes on tx0..tx6, sets the count on spi_n and pulses spi_go.
- The block shifts the bytes MSB-first on one chip-select frame and captures MISO into rx0..rx6.
- It reports progress on ss_state and pulses spi_ok when the frame is complete.

Parameters:
CLK_DIV, 6, clk cycles per SCK half-period (1 MHz SCK at 12 MHz clk); legal range 2..255
CS_SETUP, 2, clk cycles from cs_n fall to the first SCK rising edge phase start
CS_HOLD, 2, clk cycles from the last SCK falling edge to cs_n rise
CS_IDLE, 4, minimum clk cycles cs_n stays high before spi_ok and return to idle

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tx0..tx6  input  8 each  transmit bytes; tx0 is sent first
spi_n  input  3  byte count for the frame
spi_go  input  1  single-cycle start strobe
rx0..rx6  output  8 each  received bytes; rx0 is the first received
spi_ok  output  1  one-cycle frame-done pulse
ss_state  output  4  current state code; 0 = idle
sck  output  1  SPI clock
mosi  output  1  SPI data out
miso  input  1  SPI data in
cs_n  output  1  chip select, active low

Behaviour:
- Reset (reset low, asynchronous):
  - cs_n=1, sck=0, mosi=0, spi_ok=0, ss_state=0, rx0..rx6=0.
  - Any transfer in progress is abandoned; no spi_ok is issued for it.
- State codes on ss_state: 0 IDLE, 1 SETUP, 2 LOW, 3 HIGH, 4 HOLD, 5 GAP. Codes 6..15 are unused; an illegal state recovers to IDLE with cs_n=1.
- IDLE:
  - On spi_go=1 with spi_n in 1..7: latch tx0..tx6 and spi_n into internal buffers the same cycle, then go to SETUP next cycle.
  - spi_n=0 with spi_go: ignored (no frame, no spi_ok).
  - spi_n is 3 bits, so 7 is the maximum count.
- spi_go outside IDLE is ignored. Inputs tx*/spi_n may change freely after the go cycle.
- SETUP:
  - cs_n=0 and mosi=tx0[7] from the first SETUP cycle.
  - Hold for CS_SETUP cycles, then go to LOW.
- LOW: sck=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - On entry, sck=1 and miso is sampled into the shift register.
  - Hold CLK_DIV cycles.
  - On exit, sck=0. If bits remain, mosi takes the next bit and the state returns to LOW.
  - After bit 8*spi_n, go to HOLD.
- HOLD:
  - sck=0; cs_n stays 0 for CS_HOLD cycles, then cs_n=1 and go to GAP.
  - Each completed byte is written to rx[k] at its 8th sample.
- GAP: hold CS_IDLE cycles, then go to IDLE. spi_ok=1 for exactly one cycle, in the first IDLE cycle. rx0..rx(n-1) are stable and valid in that cycle.
- rx registers for byte indices ≥ spi_n keep their previous values.
- A spi_go in the same cycle as spi_ok is accepted (back-to-back frames allowed).
- Bit order and data:
  - MSB-first within a byte; bytes in order tx0, tx1, ...
  - The received byte k is the 8 miso samples of byte slot k.
- Frame timing:
  - cs_n low duration = CS_SETUP + 16·CLK_DIV·spi_n + CS_HOLD cycles.
  - go-to-spi_ok latency = 1 + that duration + CS_IDLE cycles.
- Idle outputs: sck=0, mosi=0 whenever cs_n=1. Exactly 8·spi_n rising edges occur per frame.
- Counters:
  - Bit counter is 6 bits (max 56).
  - Divider counter is 8 bits and wraps only by reload; it never free-runs.

Test Plan:
- Defaults, tx=02 02 18 E8 17 70 00, spi_n=7, go → cs_n low for 676 cycles; mosi bitstream 0x02 02 18 E8 17 70 00 MSB-first; 56 sck rising edges; spi_ok exactly 1 cycle, 681 cycles after go; ss_state=0 during spi_ok.
- 4-byte status read tx=03 00 00 00, slave model drives 0x00,0x00,0x00,0x40 → rx3=0x40 when spi_ok=1; rx4..rx6 unchanged from their prior values (preload 0xAA via an earlier frame).
- 7-byte read, slave returns 00 00 00 01 19 00 00 → rx3=0x01, rx4=0x19, rx5=0x00, rx6=0x00; loopback miso=mosi on a second frame → rxk=txk for all 7.
- spi_go pulsed during HIGH of byte 2 and spi_go with spi_n=0 while idle → no extra cs_n fall, no extra spi_ok, current frame bitstream unchanged.
- Back-to-back: go asserted in the spi_ok cycle → new SETUP next cycle; cs_n high gap ≥ CS_IDLE (4) cycles between frames.
- reset driven low mid-byte 3 → cs_n=1, sck=0, mosi=0, ss_state=0 within the same cycle (async); rx cleared; no spi_ok; a subsequent normal frame completes correctly.
